// File: rtl/writeback_hilo_if.sv
// writeback_hilo_if
// Bundles the memory-stage inputs and writeback-stage outputs of the
// writeback_hilo stage.
//   slave  : the writeback stage (consumes *M, produces *W)
//   master : whoever drives the M stage and observes W (pipeline / bench)
// Handshake: there is no ready path. validM qualifies the M-stage fields
// and is captured whenever W is not stalled. validW qualifies the W-stage
// fields. stallW/flushW are plain ports on the stage itself.
interface writeback_hilo_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) ();
  // M-stage control
  logic          validM;
  logic          RegWriteM;
  logic          LinkM;
  logic          HiLoWriteM;
  logic [2:0]    ResultSrcM;
  logic [2:0]    LoadTypeM;
  logic [1:0]    AddrLowM;
  logic [AW-1:0] WriteRegM;
  // M-stage data
  logic [DW-1:0] ALUOutM;
  logic [DW-1:0] ReadDataM;
  logic [DW-1:0] PCPlus8M;
  logic [DW-1:0] MultHiM;
  logic [DW-1:0] MultLoM;
  // W-stage outputs
  logic             validW;
  logic             RegWriteW;
  logic [AW-1:0]    WriteRegW;
  logic [DW-1:0]    ResultW;
  logic [DW-1:0]    HiW;
  logic [DW-1:0]    LoW;
  logic [CNT_W-1:0] RetiredW;

  modport slave (
    input  validM, RegWriteM, LinkM, HiLoWriteM, ResultSrcM, LoadTypeM,
           AddrLowM, WriteRegM, ALUOutM, ReadDataM, PCPlus8M, MultHiM, MultLoM,
    output validW, RegWriteW, WriteRegW, ResultW, HiW, LoW, RetiredW
  );

  modport master (
    output validM, RegWriteM, LinkM, HiLoWriteM, ResultSrcM, LoadTypeM,
           AddrLowM, WriteRegM, ALUOutM, ReadDataM, PCPlus8M, MultHiM, MultLoM,
    input  validW, RegWriteW, WriteRegW, ResultW, HiW, LoW, RetiredW
  );
endinterface

// File: rtl/writeback_hilo.sv
// writeback_hilo
// Writeback stage: M->W pipeline register with stall/flush, sub-word load
// extraction, architectural HI/LO registers, result select and a retired
// instruction counter.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   stallW : hold W and block commit
//   flushW : load a bubble into W (wins over stallW)
//   bus    : writeback_hilo_if.slave carrying M inputs and W outputs
// No FSM: the only state is the W register, HI/LO and the counter.
module writeback_hilo #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallW,
  input  logic             flushW,
  writeback_hilo_if.slave  bus
);

  localparam logic [AW-1:0] LP_LINK = AW'(LINK_REG);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          link;
    logic          hilowrite;
    logic [2:0]    resultsrc;
    logic [2:0]    loadtype;
    logic [1:0]    addrlow;
    logic [AW-1:0] writereg;
    logic [DW-1:0] aluout;
    logic [DW-1:0] readdata;
    logic [DW-1:0] pcplus8;
    logic [DW-1:0] multhi;
    logic [DW-1:0] multlo;
  } w_reg_t;

  w_reg_t           r_w;
  w_reg_t           w_m;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic [CNT_W-1:0] r_retired;

  logic             w_commit;
  logic [AW-1:0]    w_writereg;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [DW-1:0]    w_load;
  logic [DW-1:0]    w_result;

  always_comb begin
    w_m.valid     = bus.validM;
    w_m.regwrite  = bus.RegWriteM;
    w_m.link      = bus.LinkM;
    w_m.hilowrite = bus.HiLoWriteM;
    w_m.resultsrc = bus.ResultSrcM;
    w_m.loadtype  = bus.LoadTypeM;
    w_m.addrlow   = bus.AddrLowM;
    w_m.writereg  = bus.WriteRegM;
    w_m.aluout    = bus.ALUOutM;
    w_m.readdata  = bus.ReadDataM;
    w_m.pcplus8   = bus.PCPlus8M;
    w_m.multhi    = bus.MultHiM;
    w_m.multlo    = bus.MultLoM;
  end

  // A bubble is the same as the reset image: all control cleared, so a
  // flushed slot can never write the register file or HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w <= '0;
    end else if (flushW) begin
      r_w <= '0;
    end else if (!stallW) begin
      r_w <= w_m;
    end
  end

  // Commit looks at the resident instruction only; a stalled instruction
  // commits on the edge its stall drops, so HI/LO are written once.
  assign w_commit = r_w.valid & ~stallW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 1'b1;
      if (r_w.hilowrite) begin
        r_hi <= r_w.multhi;
        r_lo <= r_w.multlo;
      end
    end
  end

  // Lane selection works on the low 32 bits; AddrLow only reaches that far.
  always_comb begin
    w_word = 32'(r_w.readdata);
    case (r_w.addrlow)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    // AddrLow[0] is deliberately ignored for halfwords (no misalign fault).
    w_half = r_w.addrlow[1] ? w_word[31:16] : w_word[15:0];
    case (r_w.loadtype)
      3'd1:    w_load = {{(DW-8){w_byte[7]}}, w_byte};
      3'd2:    w_load = {{(DW-8){1'b0}}, w_byte};
      3'd3:    w_load = {{(DW-16){w_half[15]}}, w_half};
      3'd4:    w_load = {{(DW-16){1'b0}}, w_half};
      default: w_load = r_w.readdata;
    endcase
  end

  always_comb begin
    case (r_w.resultsrc)
      3'd1:    w_result = w_load;
      3'd2:    w_result = r_w.pcplus8;
      3'd3:    w_result = r_hi;
      3'd4:    w_result = r_lo;
      default: w_result = r_w.aluout;
    endcase
  end

  assign w_writereg = r_w.link ? LP_LINK : r_w.writereg;

  assign bus.validW    = r_w.valid;
  // Held high through a stall; re-writing the same value is harmless.
  assign bus.RegWriteW = r_w.valid & r_w.regwrite & (w_writereg != '0);
  assign bus.WriteRegW = w_writereg;
  assign bus.ResultW   = w_result;
  assign bus.HiW       = r_hi;
  assign bus.LoW       = r_lo;
  assign bus.RetiredW  = r_retired;

endmodule

// File: tb/tb_writeback_hilo.sv
module tb_writeback_hilo;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        link;
    logic        hilowrite;
    logic [2:0]  src;
    logic [2:0]  ltype;
    logic [1:0]  alow;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc8;
    logic [31:0] mhi;
    logic [31:0] mlo;
  } instr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stallW = 1'b0;
  logic flushW = 1'b0;
  always #5 clk = ~clk;

  writeback_hilo_if #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) bus ();

  writeback_hilo #(.DW(DW), .AW(AW), .LINK_REG(31), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .stallW (stallW),
    .flushW (flushW),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Architectural view: the instruction sitting in W, HI, LO and the total
  // number of committed instructions (reported modulo 2^CNT_W).
  instr_t m_in;
  instr_t m_w;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int m_ret;

  function automatic logic [4:0] exp_wreg(input instr_t t);
    return t.link ? 5'd31 : t.wreg;
  endfunction

  function automatic logic exp_regwrite(input instr_t t);
    return t.valid && t.regwrite && (exp_wreg(t) != 5'd0);
  endfunction

  function automatic logic [31:0] exp_load(input instr_t t);
    int unsigned b;
    int unsigned h;
    b = (t.rdata >> (8 * t.alow)) & 32'hFF;
    h = (t.rdata >> (16 * (t.alow / 2))) & 32'hFFFF;
    case (t.ltype)
      3'd1: return (b >= 128) ? (b - 256) : b;
      3'd2: return b;
      3'd3: return (h >= 32768) ? (h - 65536) : h;
      3'd4: return h;
      default: return t.rdata;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input instr_t t);
    case (t.src)
      3'd1: return exp_load(t);
      3'd2: return t.pc8;
      3'd3: return m_hi;
      3'd4: return m_lo;
      default: return t.alu;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid     = ($urandom_range(0, 9) != 0);
    t.regwrite  = ($urandom_range(0, 3) != 0);
    t.link      = ($urandom_range(0, 7) == 0);
    t.hilowrite = ($urandom_range(0, 4) == 0);
    t.src       = 3'($urandom_range(0, 7));
    t.ltype     = 3'($urandom_range(0, 7));
    t.alow      = 2'($urandom_range(0, 3));
    t.wreg      = 5'($urandom_range(0, 31));
    t.alu       = $urandom;
    t.rdata     = $urandom;
    t.pc8       = $urandom;
    t.mhi       = $urandom;
    t.mlo       = $urandom;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_m(input instr_t t);
    m_in           = t;
    bus.validM     = t.valid;
    bus.RegWriteM  = t.regwrite;
    bus.LinkM      = t.link;
    bus.HiLoWriteM = t.hilowrite;
    bus.ResultSrcM = t.src;
    bus.LoadTypeM  = t.ltype;
    bus.AddrLowM   = t.alow;
    bus.WriteRegM  = t.wreg;
    bus.ALUOutM    = t.alu;
    bus.ReadDataM  = t.rdata;
    bus.PCPlus8M   = t.pc8;
    bus.MultHiM    = t.mhi;
    bus.MultLoM    = t.mlo;
  endtask

  // One clock edge with the given stall/flush; the model advances by the
  // architectural rules, then outputs are sampled 1 ns after the edge.
  task automatic step(input logic st, input logic fl);
    stallW = st;
    flushW = fl;
    if (m_w.valid && !st) begin
      m_ret = m_ret + 1;
      if (m_w.hilowrite) begin
        m_hi = m_w.mhi;
        m_lo = m_w.mlo;
      end
    end
    if (fl) m_w = '0;
    else if (!st) m_w = m_in;
    @(posedge clk);
    #1;
    stallW = 1'b0;
    flushW = 1'b0;
  endtask

  task automatic model_reset();
    m_w   = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_ret = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic instr_t alu_op(input logic [4:0] rd, input logic [31:0] v);
    instr_t t;
    t          = '0;
    t.valid    = 1'b1;
    t.regwrite = 1'b1;
    t.wreg     = rd;
    t.alu      = v;
    return t;
  endfunction

  function automatic instr_t load_op(input logic [2:0] lt, input logic [1:0] al);
    instr_t t;
    t          = alu_op(5'd9, 32'h0);
    t.src      = 3'd1;
    t.ltype    = lt;
    t.alow     = al;
    t.rdata    = 32'h80FF7F01;
    return t;
  endfunction

  function automatic instr_t mult_op(input logic [31:0] hi, input logic [31:0] lo);
    instr_t t;
    t           = '0;
    t.valid     = 1'b1;
    t.hilowrite = 1'b1;
    t.mhi       = hi;
    t.mlo       = lo;
    return t;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    instr_t t;
    // Power-on state
    checks++; if (bus.validW !== 1'b0 || bus.RegWriteW !== 1'b0 || bus.RetiredW !== 4'd0) begin
      failures++; $display("FAIL por_state valid=%b rw=%b ret=%0d required 0/0/0", bus.validW, bus.RegWriteW, bus.RetiredW);
    end
    do_reset();
    // Build non-zero state, then reset mid-cycle while stalled
    drive_m(mult_op(32'hAAAA5555, 32'h1234ABCD));
    step(1'b0, 1'b0);
    drive_m(alu_op(5'd3, 32'h0000_0777));
    step(1'b0, 1'b0);
    checks++; if (bus.HiW !== 32'hAAAA5555 || bus.validW !== 1'b1) begin
      failures++; $display("FAIL pre_reset_state hi=%h valid=%b required aaaa5555/1", bus.HiW, bus.validW);
    end
    stallW = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.validW !== 1'b0 || bus.RegWriteW !== 1'b0 || bus.WriteRegW !== 5'd0 || bus.ResultW !== 32'd0) begin
      failures++; $display("FAIL async_reset_w got v=%b rw=%b wr=%0d res=%h required all zero", bus.validW, bus.RegWriteW, bus.WriteRegW, bus.ResultW);
    end
    checks++; if (bus.HiW !== 32'd0 || bus.LoW !== 32'd0 || bus.RetiredW !== 4'd0) begin
      failures++; $display("FAIL async_reset_hilo got hi=%h lo=%h ret=%0d required zero", bus.HiW, bus.LoW, bus.RetiredW);
    end
    rst = 1'b1;
    stallW = 1'b0;
    t = alu_op(5'd5, 32'h0000_1234);
    drive_m(t);
    step(1'b0, 1'b0);
    checks++; if (bus.RegWriteW !== 1'b1 || bus.WriteRegW !== 5'd5 || bus.ResultW !== 32'h0000_1234) begin
      failures++; $display("FAIL post_reset_alu got rw=%b wr=%0d res=%h required 1/5/00001234", bus.RegWriteW, bus.WriteRegW, bus.ResultW);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt[6]  = '{3'd1, 3'd1, 3'd4, 3'd3, 3'd2, 3'd3};
    logic [1:0]  al[6]  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] exp[6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF,
                            32'hFFFF80FF, 32'h00000080, 32'h00007F01};
    for (int i = 0; i < 6; i++) begin
      drive_m(load_op(lt[i], al[i]));
      step(1'b0, 1'b0);
      checks++; if (bus.ResultW !== exp[i]) begin
        failures++; $display("FAIL load_%0d type=%0d addr=%0d got=%h required=%h", i, lt[i], al[i], bus.ResultW, exp[i]);
      end
    end
  endtask

  task automatic test_mult_mfhi();
    instr_t t;
    drive_m(mult_op(32'hDEAD0000, 32'h0000BEEF));
    step(1'b0, 1'b0);
    t = alu_op(5'd8, 32'h0);
    t.src = 3'd3;
    drive_m(t);
    step(1'b0, 1'b0);
    checks++; if (bus.HiW !== 32'hDEAD0000 || bus.LoW !== 32'h0000BEEF) begin
      failures++; $display("FAIL mult_hilo got hi=%h lo=%h required dead0000/0000beef", bus.HiW, bus.LoW);
    end
    checks++; if (bus.ResultW !== 32'hDEAD0000) begin
      failures++; $display("FAIL mfhi_result got=%h required=dead0000", bus.ResultW);
    end
    t.src = 3'd4;
    drive_m(t);
    step(1'b0, 1'b0);
    checks++; if (bus.ResultW !== 32'h0000BEEF) begin
      failures++; $display("FAIL mflo_result got=%h required=0000beef", bus.ResultW);
    end
  endtask

  task automatic test_stall_hilo();
    logic [31:0] hi0;
    logic [3:0]  ret0;
    drive_m(mult_op(32'h13572468, 32'h99887766));
    step(1'b0, 1'b0);
    hi0  = m_hi;
    ret0 = 4'(m_ret);
    drive_m(alu_op(5'd4, 32'h55));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      checks++; if (bus.HiW !== hi0 || bus.RetiredW !== ret0 || bus.validW !== 1'b1) begin
        failures++; $display("FAIL stall_hold_%0d got hi=%h ret=%0d v=%b required %h/%0d/1", i, bus.HiW, bus.RetiredW, bus.validW, hi0, ret0);
      end
    end
    step(1'b0, 1'b0);
    checks++; if (bus.HiW !== 32'h13572468 || bus.LoW !== 32'h99887766 || bus.RetiredW !== ret0 + 4'd1) begin
      failures++; $display("FAIL stall_release got hi=%h lo=%h ret=%0d required 13572468/99887766/%0d", bus.HiW, bus.LoW, bus.RetiredW, ret0 + 4'd1);
    end
  endtask

  task automatic test_flush_stall();
    logic [31:0] hi0;
    logic [3:0]  ret0;
    drive_m(mult_op(32'hCAFEF00D, 32'h0BADBEEF));
    step(1'b0, 1'b0);
    hi0  = m_hi;
    ret0 = 4'(m_ret);
    step(1'b1, 1'b1);
    checks++; if (bus.validW !== 1'b0 || bus.RetiredW !== ret0 || bus.HiW !== hi0) begin
      failures++; $display("FAIL flush_stall got v=%b ret=%0d hi=%h required 0/%0d/%h", bus.validW, bus.RetiredW, bus.HiW, ret0, hi0);
    end
    drive_m(alu_op(5'd2, 32'h1));
    step(1'b0, 1'b0);
    checks++; if (bus.RetiredW !== ret0 || bus.HiW !== hi0) begin
      failures++; $display("FAIL flush_no_commit got ret=%0d hi=%h required %0d/%h", bus.RetiredW, bus.HiW, ret0, hi0);
    end
  endtask

  task automatic test_link_r0();
    instr_t t;
    t = alu_op(5'd7, 32'hFFFF0000);
    t.link = 1'b1;
    t.src  = 3'd2;
    t.pc8  = 32'h00400010;
    drive_m(t);
    step(1'b0, 1'b0);
    checks++; if (bus.WriteRegW !== 5'd31 || bus.ResultW !== 32'h00400010 || bus.RegWriteW !== 1'b1) begin
      failures++; $display("FAIL link got wr=%0d res=%h rw=%b required 31/00400010/1", bus.WriteRegW, bus.ResultW, bus.RegWriteW);
    end
    drive_m(alu_op(5'd0, 32'h42));
    step(1'b0, 1'b0);
    checks++; if (bus.RegWriteW !== 1'b0 || bus.validW !== 1'b1) begin
      failures++; $display("FAIL r0_write got rw=%b v=%b required 0/1", bus.RegWriteW, bus.validW);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_m(alu_op(5'(i + 1), 32'(i)));
      step(1'b0, 1'b0);
    end
    checks++; if (bus.RetiredW !== 4'd0) begin
      failures++; $display("FAIL wrap_16 got=%0d required=0", bus.RetiredW);
    end
    drive_m('0);
    step(1'b0, 1'b0);
    checks++; if (bus.RetiredW !== 4'd1) begin
      failures++; $display("FAIL wrap_17 got=%0d required=1", bus.RetiredW);
    end
  endtask

  task automatic test_back_to_back();
    instr_t t;
    logic st;
    logic fl;
    for (int i = 0; i < 300; i++) begin
      t  = rand_instr();
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      drive_m(t);
      step(st, fl);
      checks++; if (bus.validW !== m_w.valid || bus.RegWriteW !== exp_regwrite(m_w) || bus.WriteRegW !== exp_wreg(m_w)) begin
        failures++; $display("FAIL rand_ctrl_%0d got v=%b rw=%b wr=%0d required %b/%b/%0d", i, bus.validW, bus.RegWriteW, bus.WriteRegW, m_w.valid, exp_regwrite(m_w), exp_wreg(m_w));
      end
      checks++; if (bus.ResultW !== exp_result(m_w)) begin
        failures++; $display("FAIL rand_result_%0d got=%h required=%h", i, bus.ResultW, exp_result(m_w));
      end
      checks++; if (bus.HiW !== m_hi || bus.LoW !== m_lo || bus.RetiredW !== 4'(m_ret)) begin
        failures++; $display("FAIL rand_arch_%0d got hi=%h lo=%h ret=%0d required %h/%h/%0d", i, bus.HiW, bus.LoW, bus.RetiredW, m_hi, m_lo, 4'(m_ret));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    drive_m('0);
    #3;
    test_reset();
    test_loads();
    test_mult_mfhi();
    test_stall_hilo();
    test_flush_stall();
    test_link_r0();
    test_counter_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
